instruction_executor: RTL and testbench

INSTRUCTION_EXECUTOR -- requirements
Module: instruction_executor

---
 rtl/instruction_executor_pkg.sv | 18 +
 rtl/instruction_executor.sv | 155 +++++++++++++++
 tb/tb_instruction_executor.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_executor_pkg.sv
// Shared constants for the instruction executor: opcodes and the field and port widths.
package instruction_executor_pkg;

  localparam int unsigned InstrWidth     = 32;
  localparam int unsigned ResultWidth    = 16;
  localparam int unsigned MemAddrWidth   = 16;
  localparam int unsigned OpcodeWidth    = 4;
  localparam int unsigned XWidth         = 8;
  localparam int unsigned YWidth         = 7;
  localparam int unsigned ColourWidth    = 3;
  localparam int unsigned StoreDataWidth = 12;

  localparam logic [OpcodeWidth-1:0] OpNop   = 4'd0;
  localparam logic [OpcodeWidth-1:0] OpDraw  = 4'd1;
  localparam logic [OpcodeWidth-1:0] OpLoad  = 4'd2;
  localparam logic [OpcodeWidth-1:0] OpStore = 4'd3;

endpackage

// File: rtl/instruction_executor.sv
// Multi-cycle executor for NOP/DRAW/LOAD/STORE words; drives a data memory and a VGA
// plot port. All outputs are registered.
module instruction_executor
  import instruction_executor_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = InstrWidth,
  parameter int unsigned RESULT_WIDTH      = ResultWidth,
  parameter int unsigned MEM_ADDR_WIDTH    = MemAddrWidth
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         finished,
  output logic [RESULT_WIDTH-1:0]      result,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_address,
  output logic                         mem_wren,
  output logic [RESULT_WIDTH-1:0]      mem_data,
  input  logic [RESULT_WIDTH-1:0]      mem_q,
  output logic [XWidth-1:0]            vga_x,
  output logic [YWidth-1:0]            vga_y,
  output logic [ColourWidth-1:0]       vga_colour,
  output logic                         vga_plot,
  output logic                         illegal
);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StLoadWait,
    StLoadCapture,
    StDone
  } state_e;

  state_e                       state_q, state_d;
  logic                         start_prev_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic                         finished_q, finished_d;
  logic [RESULT_WIDTH-1:0]      result_q, result_d;
  logic [MEM_ADDR_WIDTH-1:0]    mem_address_q, mem_address_d;
  logic                         mem_wren_q, mem_wren_d;
  logic [RESULT_WIDTH-1:0]      mem_data_q, mem_data_d;
  logic [XWidth-1:0]            vga_x_q, vga_x_d;
  logic [YWidth-1:0]            vga_y_q, vga_y_d;
  logic [ColourWidth-1:0]       vga_colour_q, vga_colour_d;
  logic                         vga_plot_q, vga_plot_d;
  logic                         illegal_q, illegal_d;
  logic [OpcodeWidth-1:0]       opcode;

  assign opcode = instr_q[31:28];

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    finished_d    = finished_q;
    result_d      = result_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    vga_x_d       = vga_x_q;
    vga_y_d       = vga_y_q;
    vga_colour_d  = vga_colour_q;
    illegal_d     = illegal_q;
    // Strobes default low so they last exactly one cycle.
    mem_wren_d    = 1'b0;
    vga_plot_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !start_prev_q) begin
          instr_d    = instruction;
          finished_d = 1'b0;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        state_d = StDone;
        case (opcode)
          OpNop: ;
          OpDraw: begin
            vga_x_d      = instr_q[7:0];
            vga_y_d      = instr_q[14:8];
            vga_colour_d = instr_q[17:15];
            vga_plot_d   = instr_q[18];
          end
          OpStore: begin
            mem_address_d = MEM_ADDR_WIDTH'(instr_q[15:0]);
            mem_data_d    = RESULT_WIDTH'(instr_q[27:16]);
            mem_wren_d    = 1'b1;
          end
          OpLoad: begin
            mem_address_d = MEM_ADDR_WIDTH'(instr_q[15:0]);
            state_d       = StLoadWait;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      StLoadWait: state_d = StLoadCapture;
      StLoadCapture: begin
        result_d   = mem_q;
        finished_d = 1'b1;
        state_d    = StIdle;
      end
      StDone: begin
        finished_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset has priority, so an operation caught mid-flight produces no strobe or result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      start_prev_q  <= 1'b0;
      instr_q       <= '0;
      finished_q    <= 1'b1;
      result_q      <= '0;
      mem_address_q <= '0;
      mem_wren_q    <= 1'b0;
      mem_data_q    <= '0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start;
      instr_q       <= instr_d;
      finished_q    <= finished_d;
      result_q      <= result_d;
      mem_address_q <= mem_address_d;
      mem_wren_q    <= mem_wren_d;
      mem_data_q    <= mem_data_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      vga_plot_q    <= vga_plot_d;
      illegal_q     <= illegal_d;
    end
  end

  assign finished    = finished_q;
  assign result      = result_q;
  assign mem_address = mem_address_q;
  assign mem_wren    = mem_wren_q;
  assign mem_data    = mem_data_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign vga_plot    = vga_plot_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_instruction_executor.sv
// Directed bench for instruction_executor with a strobe/result scoreboard and a
// one-register read-latency memory model.
module tb_instruction_executor;
  import instruction_executor_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic        finished;
  logic [15:0] result;
  logic [15:0] mem_address;
  logic        mem_wren;
  logic [15:0] mem_data;
  logic [15:0] mem_q;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        illegal;

  instruction_executor dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .finished    (finished),
    .result      (result),
    .mem_address (mem_address),
    .mem_wren    (mem_wren),
    .mem_data    (mem_data),
    .mem_q       (mem_q),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:65535];
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} plot_t;
  typedef struct packed {logic [15:0] a; logic [15:0] d;} wr_t;

  plot_t       plot_q[$];
  wr_t         wr_q[$];
  logic [15:0] res_q[$];
  int          total = 0;
  int          bad = 0;
  int          n_plot = 0;
  int          n_wren = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock, then sample and score any strobe seen in this cycle.
  task automatic tick();
    plot_t p;
    wr_t   w;
    @(posedge clock);
    #1;
    if (vga_plot === 1'b1) begin
      n_plot++;
      chk("plot_pending", 32'(plot_q.size() != 0), 32'd1);
      if (plot_q.size() != 0) begin
        p = plot_q.pop_front();
        chk("plot_pixel", 32'({vga_x, vga_y, vga_colour}), 32'(p));
      end
    end
    if (mem_wren === 1'b1) begin
      n_wren++;
      chk("wren_pending", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        chk("wren_addr_data", {mem_address, mem_data}, 32'(w));
      end
    end
  endtask

  // Start held two cycles, then wait (bounded) for finished and check latency.
  task automatic run_op(input string tag, input logic [31:0] instr, input int exp_lat);
    int          n;
    logic [15:0] r;
    start = 1'b1;
    instruction = instr;
    tick();
    chk({tag, "_busy"}, 32'(finished), 32'd0);
    tick();
    start = 1'b0;
    n = 1;
    while (finished !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    if (instr[31:28] == OpLoad && res_q.size() != 0) begin
      r = res_q.pop_front();
      chk({tag, "_result"}, 32'(result), 32'(r));
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instruction = '0;
    tick();
    tick();
    chk("rst_finished", 32'(finished), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    reset = 1'b0;
    tick();

    // DRAW x=37 y=12 colour=3 plot=1
    plot_q.push_back('{x: 8'd37, y: 7'd12, c: 3'b011});
    run_op("draw", {4'd1, 9'h1FF, 1'b1, 3'b011, 7'd12, 8'd37}, 2);
    chk("draw_once", 32'(n_plot), 32'd1);
    chk("draw_hold_x", 32'(vga_x), 32'd37);

    // DRAW with plot bit clear: pixel registers update, no strobe
    run_op("draw_noplot", {4'd1, 9'h0, 1'b0, 3'b101, 7'd100, 8'd200}, 2);
    chk("noplot_count", 32'(n_plot), 32'd1);
    chk("noplot_xyc", 32'({vga_x, vga_y, vga_colour}), 32'({8'd200, 7'd100, 3'b101}));

    // STORE 0xABC @ 0x0040, then LOAD it back
    wr_q.push_back('{a: 16'h0040, d: 16'h0ABC});
    run_op("store", {4'd3, 12'hABC, 16'h0040}, 2);
    chk("store_once", 32'(n_wren), 32'd1);
    chk("store_hold_addr", 32'(mem_address), 32'h0040);
    res_q.push_back(16'h0ABC);
    run_op("load", {4'd2, 12'hFFF, 16'h0040}, 3);

    // Non-LOAD leaves result alone
    run_op("nop", {4'd0, 28'hFFFFFFF}, 2);
    chk("nop_result", 32'(result), 32'h0ABC);

    // Illegal opcode: sticky flag, no strobes
    run_op("illegal", {4'd9, 28'h1234567}, 2);
    chk("illegal_set", 32'(illegal), 32'd1);
    run_op("nop2", {4'd0, 28'h0}, 2);
    chk("illegal_sticky", 32'(illegal), 32'd1);
    chk("illegal_strobes", 32'(n_plot + n_wren), 32'd2);

    // Start re-raised during LOAD_WAIT must be ignored
    res_q.push_back(16'h0ABC);
    start = 1'b1;
    instruction = {4'd2, 12'h000, 16'h0040};
    tick();  // accept
    start = 1'b0;
    instruction = {4'd3, 12'h123, 16'h0040};
    tick();  // decode
    start = 1'b1;
    tick();  // load_wait
    chk("tog_busy", 32'(finished), 32'd0);
    tick();  // capture
    chk("tog_finished", 32'(finished), 32'd1);
    chk("tog_result", 32'(result), 32'(res_q.pop_front()));
    tick();
    tick();
    chk("tog_no_retrigger", 32'(finished), 32'd1);
    start = 1'b0;
    tick();
    tick();
    chk("tog_no_wren", 32'(n_wren), 32'd1);

    // Reset while a STORE sits in DECODE
    start = 1'b1;
    instruction = {4'd3, 12'h555, 16'h0077};
    tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    chk("rstmid_wren", 32'(mem_wren), 32'd0);
    chk("rstmid_finished", 32'(finished), 32'd1);
    chk("rstmid_result", 32'(result), 32'd0);
    chk("rstmid_mem", {mem_address, mem_data}, 32'd0);
    chk("rstmid_vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
    chk("rstmid_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmid_no_wren", 32'(n_wren), 32'd1);
    chk("queues_empty", 32'(plot_q.size() + wr_q.size() + res_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
